// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width, mult/div opcodes and FSM states.
package mips_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'b00,
    MD_CALC   = 2'b01,
    MD_FINISH = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_datapath_step.sv
// One radix-2 iteration: shift-add multiply step or restoring shift-subtract divide step.
module md_datapath_step
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] trial;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, b};
    rem      = {acc, q[WIDTH-1]};
    trial    = rem - {1'b0, b};
    acc_next = acc;
    q_next   = q;
    if (is_div) begin
      // The borrow bit of the trial subtraction decides the quotient bit.
      if (!trial[WIDTH]) begin
        acc_next = trial[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else if (q[0]) begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[WIDTH-1:1]};
      q_next   = {acc[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; Busy stalls the pipeline.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  input  logic             MtHi,
  input  logic             MtLo,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  md_state_e        state, state_next;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, qreg, breg, a_lat;
  logic             neg_q, neg_r, dbz;
  logic [WIDTH-1:0] acc_next, q_next;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;
  logic             start_ok, signed_op;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign start_ok  = (state == MD_IDLE) && Start && !Flush;
  assign signed_op = (Op == MD_MULT) || (Op == MD_DIV);
  assign mag_a     = (signed_op && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign mag_b     = (signed_op && OperandB[WIDTH-1]) ? -OperandB : OperandB;
  assign Busy      = (state != MD_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= MD_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE:   if (Start && !Flush) state_next = MD_CALC;
      MD_CALC: begin
        if (Flush)                         state_next = MD_IDLE;
        else if (cnt == {CNT_W{1'b1}})     state_next = MD_FINISH;
      end
      MD_FINISH: state_next = MD_IDLE;
      default:   state_next = MD_IDLE;
    endcase
  end

  md_datapath_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_q[1]),
    .acc      (acc),
    .q        (qreg),
    .b        (breg),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  // Operand capture at launch, then one iteration per CALC cycle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q  <= MD_MULT;
      cnt   <= '0;
      acc   <= '0;
      qreg  <= '0;
      breg  <= '0;
      a_lat <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz   <= 1'b0;
    end else if (start_ok) begin
      op_q  <= md_op_e'(Op);
      cnt   <= '0;
      acc   <= '0;
      qreg  <= mag_a;
      breg  <= mag_b;
      a_lat <= OperandA;
      neg_q <= signed_op && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
      neg_r <= (Op == MD_DIV) && OperandA[WIDTH-1];
      dbz   <= (OperandB == '0);
    end else if (state == MD_CALC) begin
      acc  <= acc_next;
      qreg <= q_next;
      cnt  <= cnt + 1'b1;
    end
  end

  // Sign fixup of the magnitude result; divide-by-zero bypasses the datapath result
  always_comb begin
    prod   = {acc, qreg};
    res_hi = acc;
    res_lo = qreg;
    if (!op_q[1]) begin
      {res_hi, res_lo} = neg_q ? -prod : prod;
    end else if (dbz) begin
      res_hi = a_lat;
      res_lo = '1;
    end else begin
      res_lo = neg_q ? -qreg : qreg;
      res_hi = neg_r ? -acc : acc;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Hi   <= '0;
      Lo   <= '0;
      Done <= 1'b0;
    end else begin
      Done <= (state == MD_FINISH);
      if (state == MD_FINISH) begin
        Hi <= res_hi;
        Lo <= res_lo;
      end else if (state == MD_IDLE && !start_ok) begin
        if (MtHi) Hi <= OperandA;
        if (MtLo) Lo <= OperandA;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle-level countdown reference model plus directed literal checks.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Start = 1'b0, Flush = 1'b0, MtHi = 1'b0, MtLo = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] OperandA = '0, OperandB = '0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  always #5 Clk = ~Clk;

  mult_div_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
    .MtHi(MtHi), .MtLo(MtLo), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from the ISA definition
  function automatic void ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin sp = longint'(sa) * longint'(sb); {hi, lo} = sp; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
      2'b10: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      default: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // Reference model: m_rem counts the busy cycles still to come (33 after launch)
  int          m_rem = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_rem = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_rem == 1) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_rem = 0;
      end else if (m_rem > 1) begin
        m_rem = Flush ? 0 : m_rem - 1;
      end else if (Start && !Flush) begin
        ref_result(Op, OperandA, OperandB, p_hi, p_lo);
        m_rem = 33;
      end else begin
        if (MtHi) m_hi = OperandA;
        if (MtLo) m_lo = OperandA;
      end
    end
  end

  always @(negedge Clk) begin
    if (armed) begin
      check("model_busy", {31'b0, Busy}, {31'b0, m_rem != 0});
      check("model_done", {31'b0, Done}, {31'b0, m_done});
      check("model_hi", Hi, m_hi);
      check("model_lo", Lo, m_lo);
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles, output bit got);
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (Done) got = 1'b1;
      else begin
        if (Busy) busy_cycles++;
        @(negedge Clk);
      end
    end
  endtask

  logic [1:0]  xop[6] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b01};
  logic [31:0] xa[6]  = '{32'h8000_0000, 32'hFFFF_FFF0, 32'd7, 32'd50, 32'hFFFF_FF00, 32'h1234_5678};
  logic [31:0] xb[6]  = '{32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd7, 32'd0, 32'h9ABC_DEF0};

  initial begin
    int bc;
    bit got;
    int dones;
    #1 Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    armed = 1'b1;
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_done", {31'b0, Done}, 32'd0);
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc, got);
    check("multu_done_seen", {31'b0, got}, 32'd1);
    check("multu_busy_cycles", bc, 32'd33);
    check("multu_hi", Hi, 32'hFFFF_FFFE);
    check("multu_lo", Lo, 32'h0000_0001);

    launch(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(bc, got);
    check("mult_done_seen", {31'b0, got}, 32'd1);
    check("mult_hi", Hi, 32'hFFFF_FFFF);
    check("mult_lo", Lo, 32'hFFFF_FFEB);

    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(bc, got);
    check("div_done_seen", {31'b0, got}, 32'd1);
    check("div_lo", Lo, 32'hFFFF_FFFD);
    check("div_hi", Hi, 32'hFFFF_FFFF);

    launch(2'b11, 32'd100, 32'd0);
    wait_done(bc, got);
    check("divu0_done_seen", {31'b0, got}, 32'd1);
    check("divu0_busy_cycles", bc, 32'd33);
    check("divu0_lo", Lo, 32'hFFFF_FFFF);
    check("divu0_hi", Hi, 32'd100);

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc, got);
    check("divovf_done_seen", {31'b0, got}, 32'd1);
    check("divovf_lo", Lo, 32'h8000_0000);
    check("divovf_hi", Hi, 32'd0);

    // Flush at CALC cycle 10
    launch(2'b11, 32'd50, 32'd7);
    repeat (9) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    check("flush_busy", {31'b0, Busy}, 32'd0);
    check("flush_done", {31'b0, Done}, 32'd0);
    check("flush_hi_kept", Hi, 32'd0);
    check("flush_lo_kept", Lo, 32'h8000_0000);

    // Start while busy must be ignored
    launch(2'b11, 32'd50, 32'd7);
    repeat (4) @(negedge Clk);
    Op = 2'b01; OperandA = 32'd3; OperandB = 32'd3; Start = 1'b1;
    repeat (3) @(negedge Clk);
    Start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) dones++;
      @(negedge Clk);
    end
    check("busy_start_done_count", dones, 32'd1);
    check("busy_start_lo", Lo, 32'd7);
    check("busy_start_hi", Hi, 32'd1);

    // Start together with Flush in IDLE is suppressed
    @(negedge Clk);
    Start = 1'b1; Flush = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    check("start_flush_busy", {31'b0, Busy}, 32'd0);

    @(negedge Clk);
    MtHi = 1'b1; MtLo = 1'b1; OperandA = 32'h1234_5678;
    @(negedge Clk);
    MtHi = 1'b0; MtLo = 1'b0;
    check("mt_hi", Hi, 32'h1234_5678);
    check("mt_lo", Lo, 32'h1234_5678);

    @(negedge Clk);
    MtHi = 1'b1; MtLo = 1'b1; Start = 1'b1; Op = 2'b01; OperandA = 32'hDEAD_BEEF; OperandB = 32'd2;
    @(negedge Clk);
    MtHi = 1'b0; MtLo = 1'b0; Start = 1'b0;
    check("mt_start_busy", {31'b0, Busy}, 32'd1);
    check("mt_start_hi_kept", Hi, 32'h1234_5678);
    wait_done(bc, got);
    check("mt_start_done_seen", {31'b0, got}, 32'd1);
    check("mt_start_hi", Hi, 32'd1);
    check("mt_start_lo", Lo, 32'hBD5B_7DDE);

    for (int i = 0; i < 6; i++) begin
      launch(xop[i], xa[i], xb[i]);
      wait_done(bc, got);
      check("extra_done_seen", {31'b0, got}, 32'd1);
    end

    // Asynchronous reset mid-operation at CALC cycle 20
    launch(2'b00, 32'd5, 32'd6);
    repeat (19) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, Busy}, 32'd0);
    check("arst_done", {31'b0, Done}, 32'd0);
    check("arst_hi", Hi, 32'd0);
    check("arst_lo", Lo, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    check("arst_idle_after", {31'b0, Busy}, 32'd0);

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
